// File: rtl/decimal_pkg.sv
// Shared encodings for the decimal key encoder: FSM states, key-line constants
// and the one-cold key classifier.
package decimal_pkg;

    localparam int KEY_COUNT = 10;
    localparam int BCD_W     = 4;
    localparam logic [KEY_COUNT-1:0] KEYS_NONE = 10'h3FF;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } key_class_t;

    typedef struct packed {
        key_class_t           cls;
        logic [BCD_W-1:0]     idx;
    } key_info_t;

    // idx is only meaningful when cls is CLS_SINGLE.
    function automatic key_info_t classify_keys(input logic [KEY_COUNT-1:0] keys);
        key_info_t info;
        int        lows;
        lows     = 0;
        info.idx = '0;
        info.cls = CLS_NONE;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (!keys[i]) begin
                lows     = lows + 1;
                info.idx = BCD_W'(i);
            end
        end
        if (lows == 1) begin
            info.cls = CLS_SINGLE;
        end else if (lows > 1) begin
            info.cls = CLS_MULTI;
        end
        return info;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Per-bit two-flop synchronizer with asynchronous reset to a chosen idle value.
module key_sync #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_q;
            logic sync_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_q <= RESET_VALUE[gi];
                    sync_q <= RESET_VALUE[gi];
                end else begin
                    meta_q <= async_i[gi];
                    sync_q <= meta_q;
                end
            end

            assign sync_o[gi] = sync_q;
        end
    endgenerate

endmodule

// File: rtl/decimal_key_encoder.sv
// Debounced one-cold decimal keypad to BCD encoder with multi-key rejection
// and a one-entry valid/ready output holding register.
module decimal_key_encoder
    import decimal_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = 1000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_COUNT-1:0] key_n,
    output logic [BCD_W-1:0]     digit,
    output logic                 digit_valid,
    input  logic                 digit_ready,
    output logic                 multi_err,
    output logic                 overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_COUNT-1:0] key_s;
    key_info_t            key_info;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BCD_W-1:0]     cand_q;
    logic [BCD_W-1:0]     digit_q;
    logic                 digit_valid_q;
    logic                 multi_err_q;
    logic                 overrun_q;

    logic [KEY_COUNT-1:0] cand_pattern_d;
    logic                 match_d;
    logic                 load_d;

    key_sync #(
        .WIDTH       (KEY_COUNT),
        .RESET_VALUE (KEYS_NONE)
    ) u_key_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (key_n),
        .sync_o  (key_s)
    );

    always_comb begin
        key_info       = classify_keys(key_s);
        cand_pattern_d = KEYS_NONE ^ (KEY_COUNT'(1) << cand_q);
        match_d        = (key_s == cand_pattern_d);
        load_d         = (state_q == ST_PRESS_DB) && match_d && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cand_q        <= '0;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            multi_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            multi_err_q <= (key_info.cls == CLS_MULTI);
            overrun_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (key_info.cls == CLS_SINGLE) begin
                        cand_q  <= key_info.idx;
                        cnt_q   <= '0;
                        state_q <= ST_PRESS_DB;
                    end
                end
                ST_PRESS_DB: begin
                    if (!match_d) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_HELD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    // Any other key or combination is ignored until a clean release.
                    if (key_info.cls == CLS_NONE) begin
                        cnt_q   <= '0;
                        state_q <= ST_RELEASE_DB;
                    end
                end
                ST_RELEASE_DB: begin
                    if (key_info.cls != CLS_NONE) begin
                        state_q <= ST_HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // A load while the consumer drains in the same cycle replaces the digit.
            if (load_d) begin
                if (!digit_valid_q || digit_ready) begin
                    digit_q       <= cand_q;
                    digit_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (digit_valid_q && digit_ready) begin
                digit_valid_q <= 1'b0;
            end
        end
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign multi_err   = multi_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_decimal_key_encoder.sv
// Scenario-driven bench for decimal_key_encoder with a short debounce window.
module tb_decimal_key_encoder;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] key_n;
    logic       digit_ready;
    logic [3:0] digit;
    logic       digit_valid;
    logic       multi_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    decimal_key_encoder #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .multi_err   (multi_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic release_and_wait();
        key_n = 10'h3FF;
        repeat (DB + 5) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; key_n = 10'h3FF; digit_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks += 4;
        if (digit !== 4'd0)      begin failures++; $display("FAIL reset_digit got=%0d want=0", digit); end
        if (digit_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", digit_valid); end
        if (multi_err !== 1'b0)  begin failures++; $display("FAIL reset_multi got=%b want=0", multi_err); end
        if (overrun !== 1'b0)    begin failures++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        // Leave a digit pending, then reset in the middle of another press.
        key_n = 10'h3FF ^ (10'd1 << 2);
        repeat (DB + 3) tick();
        checks += 2;
        if (digit_valid !== 1'b1) begin failures++; $display("FAIL pending_valid got=%b want=1", digit_valid); end
        if (digit !== 4'd2)       begin failures++; $display("FAIL pending_digit got=%0d want=2", digit); end
        release_and_wait();
        key_n = 10'h3FF ^ (10'd1 << 6);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (digit_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b want=0", digit_valid); end
        if (digit !== 4'd0)       begin failures++; $display("FAIL async_rst_digit got=%0d want=0", digit); end
        if (overrun !== 1'b0)     begin failures++; $display("FAIL async_rst_overrun got=%b want=0", overrun); end
        #2 rst = 1'b0;
        repeat (DB + 2) tick();
        checks++;
        if (digit_valid !== 1'b0) begin failures++; $display("FAIL rst_redebounce_early got=%b want=0", digit_valid); end
        tick();
        checks += 2;
        if (digit_valid !== 1'b1) begin failures++; $display("FAIL rst_redebounce_valid got=%b want=1", digit_valid); end
        if (digit !== 4'd6)       begin failures++; $display("FAIL rst_redebounce_digit got=%0d want=6", digit); end
        digit_ready = 1'b1;
        release_and_wait();
        checks++;
        if (digit_valid !== 1'b0) begin failures++; $display("FAIL rst_drain got=%b want=0", digit_valid); end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_clean_press();
        digit_ready = 1'b1;
        key_n = 10'h3DF;
        for (int i = 0; i <= DB + 12; i++) begin
            tick();
            checks++;
            if (digit_valid !== (i == DB + 2)) begin
                failures++; $display("FAIL clean_valid edge=%0d got=%b want=%b", i, digit_valid, (i == DB + 2));
            end
            if (i == DB + 2) begin
                checks++;
                if (digit !== 4'd5) begin failures++; $display("FAIL clean_digit got=%0d want=5", digit); end
            end
        end
        release_and_wait();
        $display("test_clean_press done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_bounce();
        int pulses, ovrs;
        logic [3:0] seen;
        pulses = 0; ovrs = 0; seen = 4'hF;
        digit_ready = 1'b1;
        for (int i = 0; i < 20 + DB + 8; i++) begin
            if (i < 20) key_n = (((i / 2) % 2) == 0) ? 10'h3FE : 10'h3FF;
            else        key_n = 10'h3FE;
            tick();
            if (digit_valid) begin pulses++; seen = digit; end
            if (overrun) ovrs++;
        end
        checks += 3;
        if (pulses != 1)    begin failures++; $display("FAIL bounce_pulses got=%0d want=1", pulses); end
        if (seen !== 4'd0)  begin failures++; $display("FAIL bounce_digit got=%0d want=0", seen); end
        if (ovrs != 0)      begin failures++; $display("FAIL bounce_overrun got=%0d want=0", ovrs); end
        release_and_wait();
        $display("test_bounce done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_multi();
        digit_ready = 1'b1;
        key_n = 10'h3F9;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (digit_valid !== 1'b0) begin failures++; $display("FAIL multi_no_valid edge=%0d got=%b want=0", i, digit_valid); end
            if (i <= 1) begin
                checks++;
                if (multi_err !== 1'b0) begin failures++; $display("FAIL multi_lag edge=%0d got=%b want=0", i, multi_err); end
            end else if (i >= 3) begin
                checks++;
                if (multi_err !== 1'b1) begin failures++; $display("FAIL multi_flag edge=%0d got=%b want=1", i, multi_err); end
            end
        end
        key_n = 10'h3FD;
        for (int i = 0; i <= DB + 4; i++) begin
            tick();
            checks++;
            if (digit_valid !== (i == DB + 2)) begin
                failures++; $display("FAIL multi_then_single_valid edge=%0d got=%b want=%b", i, digit_valid, (i == DB + 2));
            end
            if (i == DB + 2) begin
                checks++;
                if (digit !== 4'd1) begin failures++; $display("FAIL multi_then_single_digit got=%0d want=1", digit); end
            end
            if (i >= 3) begin
                checks++;
                if (multi_err !== 1'b0) begin failures++; $display("FAIL multi_clear edge=%0d got=%b want=0", i, multi_err); end
            end
        end
        release_and_wait();
        $display("test_multi done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_back_to_back();
        digit_ready = 1'b0;
        key_n = 10'h3FF ^ (10'd1 << 7);
        repeat (DB + 4) tick();
        checks += 2;
        if (digit_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=%b want=1", digit_valid); end
        if (digit !== 4'd7)       begin failures++; $display("FAIL bp_first_digit got=%0d want=7", digit); end
        release_and_wait();
        key_n = 10'h3FF ^ (10'd1 << 9);
        for (int i = 0; i <= DB + 6; i++) begin
            tick();
            checks += 3;
            if (overrun !== (i == DB + 2)) begin
                failures++; $display("FAIL bp_overrun edge=%0d got=%b want=%b", i, overrun, (i == DB + 2));
            end
            if (digit !== 4'd7)       begin failures++; $display("FAIL bp_hold_digit edge=%0d got=%0d want=7", i, digit); end
            if (digit_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid edge=%0d got=%b want=1", i, digit_valid); end
        end
        release_and_wait();
        key_n = 10'h3FF ^ (10'd1 << 9);
        for (int i = 0; i <= DB + 4; i++) begin
            digit_ready = (i == DB + 2);
            tick();
            digit_ready = 1'b0;
            if (i >= DB + 2) begin
                checks += 3;
                if (digit !== 4'd9)       begin failures++; $display("FAIL replace_digit edge=%0d got=%0d want=9", i, digit); end
                if (digit_valid !== 1'b1) begin failures++; $display("FAIL replace_valid edge=%0d got=%b want=1", i, digit_valid); end
                if (overrun !== 1'b0)     begin failures++; $display("FAIL replace_overrun edge=%0d got=%b want=0", i, overrun); end
            end
        end
        digit_ready = 1'b1;
        tick();
        checks++;
        if (digit_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b want=0", digit_valid); end
        release_and_wait();
        $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_release_debounce();
        digit_ready = 1'b1;
        key_n = 10'h3FF ^ (10'd1 << 3);
        for (int i = 0; i <= DB + 4; i++) begin
            tick();
            if (i == DB + 2) begin
                checks += 2;
                if (digit_valid !== 1'b1) begin failures++; $display("FAIL rel_first_valid got=%b want=1", digit_valid); end
                if (digit !== 4'd3)       begin failures++; $display("FAIL rel_first_digit got=%0d want=3", digit); end
            end
        end
        key_n = 10'h3FF;
        repeat (2) tick();
        key_n = 10'h3FF ^ (10'd1 << 3);
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (digit_valid !== 1'b0) begin failures++; $display("FAIL rel_glitch_valid edge=%0d got=%b want=0", i, digit_valid); end
        end
        release_and_wait();
        key_n = 10'h3FF ^ (10'd1 << 3);
        for (int i = 0; i <= DB + 3; i++) begin
            tick();
            checks++;
            if (digit_valid !== (i == DB + 2)) begin
                failures++; $display("FAIL rel_second_valid edge=%0d got=%b want=%b", i, digit_valid, (i == DB + 2));
            end
            if (i == DB + 2) begin
                checks++;
                if (digit !== 4'd3) begin failures++; $display("FAIL rel_second_digit got=%0d want=3", digit); end
            end
        end
        release_and_wait();
        $display("test_release_debounce done checks=%0d failures=%0d", checks, failures);
    endtask

    // Clean presses of random keys with random hold/gap lengths and random
    // consumer readiness; the expected holding register follows the load and
    // consume rules, with each load landing DB+2 edges after the press is sampled.
    task automatic test_random();
        logic [3:0] m_digit;
        logic       m_valid;
        logic       e_ovr;
        logic       r;
        int         k, hold, gap, load_at;
        rst = 1'b1; key_n = 10'h3FF; digit_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        m_digit = 4'd0; m_valid = 1'b0;
        for (int p = 0; p < 12; p++) begin
            k    = $urandom_range(0, 9);
            hold = DB + 3 + $urandom_range(0, 4);
            gap  = DB + 3 + $urandom_range(0, 4);
            key_n   = 10'h3FF ^ (10'd1 << k);
            load_at = cyc + 1 + DB + 2;
            for (int t = 0; t < hold + gap; t++) begin
                r = digit_ready;
                tick();
                e_ovr = 1'b0;
                if (cyc == load_at) begin
                    if (!m_valid || r) begin m_digit = 4'(k); m_valid = 1'b1; end
                    else e_ovr = 1'b1;
                end else if (m_valid && r) begin
                    m_valid = 1'b0;
                end
                checks += 4;
                if (digit_valid !== m_valid) begin failures++; $display("FAIL rand_valid press=%0d t=%0d got=%b want=%b", p, t, digit_valid, m_valid); end
                if (digit !== m_digit)       begin failures++; $display("FAIL rand_digit press=%0d t=%0d got=%0d want=%0d", p, t, digit, m_digit); end
                if (overrun !== e_ovr)       begin failures++; $display("FAIL rand_overrun press=%0d t=%0d got=%b want=%b", p, t, overrun, e_ovr); end
                if (multi_err !== 1'b0)      begin failures++; $display("FAIL rand_multi press=%0d t=%0d got=%b want=0", p, t, multi_err); end
                digit_ready = ($urandom_range(0, 2) != 0);
                if (t == hold - 1) key_n = 10'h3FF;
            end
            $display("random press %0d key=%0d hold=%0d gap=%0d digit=%0d valid=%b", p, k, hold, gap, digit, digit_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        key_n = 10'h3FF;
        digit_ready = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi();
        test_back_to_back();
        test_release_debounce();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
